wb_retire: RTL and testbench
============================

Name: wb_retire

Overview:
- Writeback/retire stage; the producer end of the register-file write port that the decode stage consumes (data word, write-enable, destination register).
- Holds the MEM/WB pipeline register and selects the writeback source.
- Sign/zero-extends and aligns load data.
- Issues exactly one register-file write and one RVFI retire pulse per committed instruction, with a 64-bit retire order counter.

Parameters:
- ORDER_W, 64, width of retire order counter (wraps modulo 2^ORDER_W).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  MEM stage holds a real instruction (0 = bubble).
- stall_i  in  1  pipeline stall; MEM/WB register holds its value.
- regwrite_i  in  1  instruction writes rd.
- rd_i  in  5  destination register.
- wb_sel_i  in  3  source select: 0 ALU, 1 CMP (zero-extended bit 0), 2 U-imm, 3 PC+4, 4 LOAD; 5-7 reserved.
- funct3_i  in  3  load type.
- pc_i  in  32  instruction PC.
- pc_wdata_i  in  32  next PC.
- alu_i  in  32  ALU result; also the load address.
- cmp_i  in  1  comparator result.
- u_imm_i  in  32  U-type immediate.
- mem_rdata_i  in  32  raw data-memory read word.
- load_regfile_o  out  1  register-file write enable.
- rd_o  out  5  register-file write address.
- regfile_in_o  out  32  register-file write data.
- rvfi_valid_o  out  1  retire pulse.
- rvfi_order_o  out  ORDER_W  order of the retiring instruction.
- rvfi_pc_o  out  32  PC of the retiring instruction.

Behaviour:
- Reset (async, active-high): MEM/WB register valid=0, all data fields 0, retired flag=0, order counter=0. All outputs 0.
- Capture: at each rising edge with stall_i=0, the MEM/WB register loads every *_i field. The retired flag clears. A captured valid_i=0 is a bubble.
- Stall: at an edge with stall_i=1, the register holds.
  - If it holds a valid, un-retired instruction, the retired flag sets at that edge.
- Latency: outputs are combinational from the MEM/WB register, one cycle after capture.
- Commit: commit = reg.valid & ~retired. An instruction commits exactly once, in the first cycle it sits in the register, regardless of stall length.
- load_regfile_o = commit & reg.regwrite & (reg.rd != 0). x0 is never written.
- rd_o = reg.rd, and regfile_in_o = selected data, even when load_regfile_o=0.
- Reserved wb_sel values: data 0.
- rvfi_valid_o = commit. rvfi_order_o = counter value. rvfi_pc_o = reg.pc.
- Order counter increments at each edge where commit=1; it wraps from all-ones to 0.
- Load alignment (wb_sel=4), byte offset off = reg.alu[1:0]:
  - LB: byte off, sign-extended.
  - LBU: byte off, zero-extended.
  - LH: halfword off[1], sign-extended; off[0] is ignored.
  - LHU: halfword off[1], zero-extended; off[0] is ignored.
  - LW: full word; off is ignored.
  - Other funct3 values: data 0.
- Simultaneous commit and new capture (stall_i=0): the current instruction commits this cycle. The counter increments and the next instruction is presented next cycle. No gap, no double count.
- Bubbles never increment the counter and never write.

Optional Feature:
- Macro WB_HALT_DETECT_EN.
- Defined: adds output halt_o (1 bit). halt_o sets sticky on a commit with reg.pc == reg.pc_wdata (jump-to-self). It clears only on rst.
- Undefined: port absent; no halt logic.

Test Plan:
- Reset mid-operation: assert rst asynchronously while a valid ALU instruction is held → all outputs 0 immediately; after release, first commit reports order 0.
- ALU write: valid, rd=5, wb_sel=0, alu=0x1234_5678, stall_i=0 → next cycle load_regfile_o=1, rd_o=5, regfile_in_o=0x12345678, rvfi_valid_o=1, order=0.
- x0 suppression: rd=0, regwrite=1 → load_regfile_o=0, rvfi_valid_o=1, order increments.
- Loads with mem_rdata=0x80F0_7F81:
  - LB off=0 → 0xFFFFFF81.
  - LBU off=3 → 0x00000080.
  - LH off=2 → 0xFFFF80F0.
  - LHU off=0 → 0x00007F81.
  - LW off=1 → 0x80F07F81.
- Stall: instruction captured, then stall_i=1 for 4 cycles → exactly one write and one rvfi_valid pulse; order increments once; outputs stay stable with enables low in cycles 2-4.
- Back-to-back plus wrap: 3 consecutive valid instructions with a bubble in between, counter preloaded via forced value 2^64-1 → orders 0xFFFF_FFFF_FFFF_FFFF, 0, 1; the bubble cycle produces no pulse. With WB_HALT_DETECT_EN defined, pc=pc_wdata=0x60 → halt_o=1 and it stays 1.

Source files
------------

// File: rtl/wb_retire_if.sv
// wb_retire_if: MEM-stage inputs and regfile/RVFI outputs of wb_retire; halt_o exists only with WB_HALT_DETECT_EN
interface wb_retire_if #(parameter int ORDER_W = 64);
  logic               valid_i;
  logic               stall_i;
  logic               regwrite_i;
  logic [4:0]         rd_i;
  logic [2:0]         wb_sel_i;
  logic [2:0]         funct3_i;
  logic [31:0]        pc_i;
  logic [31:0]        pc_wdata_i;
  logic [31:0]        alu_i;
  logic               cmp_i;
  logic [31:0]        u_imm_i;
  logic [31:0]        mem_rdata_i;
  logic               load_regfile_o;
  logic [4:0]         rd_o;
  logic [31:0]        regfile_in_o;
  logic               rvfi_valid_o;
  logic [ORDER_W-1:0] rvfi_order_o;
  logic [31:0]        rvfi_pc_o;
`ifdef WB_HALT_DETECT_EN
  logic               halt_o;
`endif
  modport master (
    output valid_i, stall_i, regwrite_i, rd_i, wb_sel_i, funct3_i, pc_i, pc_wdata_i,
           alu_i, cmp_i, u_imm_i, mem_rdata_i,
    input  load_regfile_o, rd_o, regfile_in_o, rvfi_valid_o, rvfi_order_o, rvfi_pc_o
`ifdef WB_HALT_DETECT_EN
    , input halt_o
`endif
  );
  modport slave (
    input  valid_i, stall_i, regwrite_i, rd_i, wb_sel_i, funct3_i, pc_i, pc_wdata_i,
           alu_i, cmp_i, u_imm_i, mem_rdata_i,
    output load_regfile_o, rd_o, regfile_in_o, rvfi_valid_o, rvfi_order_o, rvfi_pc_o
`ifdef WB_HALT_DETECT_EN
    , output halt_o
`endif
  );
endinterface

// File: rtl/wb_retire.sv
// wb_retire: MEM/WB register, writeback select and load alignment, one regfile write and RVFI pulse per instruction; WB_HALT_DETECT_EN adds sticky halt_o
module wb_retire #(parameter int ORDER_W = 64) (
  input logic        clk,
  input logic        rst,
  wb_retire_if.slave wb
);
  logic               valid, regwrite, cmp, retired, commit;
  logic [4:0]         rd;
  logic [2:0]         sel, funct3;
  logic [31:0]        pc, pc_wdata, alu, u_imm, rdata, load_data, wdata;
  logic [7:0]         ld_b;
  logic [15:0]        ld_h;
  logic [ORDER_W-1:0] order;
  // MEM/WB capture, retired flag so a stalled instruction commits only once, retire order counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid    <= 1'b0;
      regwrite <= 1'b0;
      cmp      <= 1'b0;
      rd       <= '0;
      sel      <= '0;
      funct3   <= '0;
      pc       <= '0;
      pc_wdata <= '0;
      alu      <= '0;
      u_imm    <= '0;
      rdata    <= '0;
      retired  <= 1'b0;
      order    <= '0;
    end else begin
      if (!wb.stall_i) begin
        valid    <= wb.valid_i;
        regwrite <= wb.regwrite_i;
        cmp      <= wb.cmp_i;
        rd       <= wb.rd_i;
        sel      <= wb.wb_sel_i;
        funct3   <= wb.funct3_i;
        pc       <= wb.pc_i;
        pc_wdata <= wb.pc_wdata_i;
        alu      <= wb.alu_i;
        u_imm    <= wb.u_imm_i;
        rdata    <= wb.mem_rdata_i;
        retired  <= 1'b0;
      end else if (commit)
        retired <= 1'b1;
      if (commit)
        order <= order + 1'b1;
    end
  // commit detection, load alignment and writeback source mux
  always_comb begin
    commit    = valid & ~retired;
    ld_b      = rdata[{alu[1:0], 3'b000} +: 8];
    ld_h      = alu[1] ? rdata[31:16] : rdata[15:0];
    load_data = funct3 == 3'd0 ? {{24{ld_b[7]}}, ld_b} :
                funct3 == 3'd4 ? {24'd0, ld_b} :
                funct3 == 3'd1 ? {{16{ld_h[15]}}, ld_h} :
                funct3 == 3'd5 ? {16'd0, ld_h} :
                funct3 == 3'd2 ? rdata : 32'd0;
    wdata     = sel == 3'd0 ? alu :
                sel == 3'd1 ? {31'd0, cmp} :
                sel == 3'd2 ? u_imm :
                sel == 3'd3 ? pc + 32'd4 :
                sel == 3'd4 ? load_data : 32'd0;
  end
  assign wb.load_regfile_o = commit & regwrite & (|rd);
  assign wb.rd_o           = rd;
  assign wb.regfile_in_o   = wdata;
  assign wb.rvfi_valid_o   = commit;
  assign wb.rvfi_order_o   = order;
  assign wb.rvfi_pc_o      = pc;
`ifdef WB_HALT_DETECT_EN
  logic halt;
  // sticky halt on committing a jump-to-self
  always_ff @(posedge clk or posedge rst)
    if (rst) halt <= 1'b0;
    else if (commit && pc == pc_wdata) halt <= 1'b1;
  assign wb.halt_o = halt;
`endif
endmodule

// File: tb/tb_wb_retire.sv
// tb_wb_retire: directed and randomized checks of wb_retire against a per-instruction retire model
module tb_wb_retire;
  localparam int OW = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wb_retire_if #(.ORDER_W(OW)) wb();
  wb_retire #(.ORDER_W(OW)) dut (.clk(clk), .rst(rst), .wb(wb));
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, regwrite, cmp;
    logic [4:0]  rd;
    logic [2:0]  sel, f3;
    logic [31:0] pc, pcw, alu, uimm, rdata;
  } ins_t;

  ins_t          h, zero_ins, r;
  bit            fresh, halt_m;
  logic [OW-1:0] cnt;
  int            errors = 0, checks = 0, pulses = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input ins_t i);
    logic [31:0] w  = i.rdata >> (8 * i.alu[1:0]);
    logic [31:0] hw = i.alu[1] ? i.rdata >> 16 : i.rdata;
    case (i.sel)
      3'd0: return i.alu;
      3'd1: return {31'd0, i.cmp};
      3'd2: return i.uimm;
      3'd3: return i.pc + 32'd4;
      3'd4:
        case (i.f3)
          3'd0: return 32'($signed(w[7:0]));
          3'd4: return {24'd0, w[7:0]};
          3'd1: return 32'($signed(hw[15:0]));
          3'd5: return {16'd0, hw[15:0]};
          3'd2: return i.rdata;
          default: return 32'd0;
        endcase
      default: return 32'd0;
    endcase
  endfunction

  function automatic ins_t mk(input bit v, input bit rw, input logic [4:0] rd, input logic [2:0] sel,
                              input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                              input logic [31:0] pc);
    ins_t i;
    i.valid = v; i.regwrite = rw; i.cmp = 1'b1; i.rd = rd; i.sel = sel; i.f3 = f3;
    i.pc = pc; i.pcw = pc + 32'd4; i.alu = alu; i.uimm = 32'hABCD_E000; i.rdata = rdata;
    return i;
  endfunction

  function automatic ins_t rnd();
    ins_t i;
    i.valid = 1'($urandom_range(0, 3) != 0); i.regwrite = 1'($urandom); i.cmp = 1'($urandom);
    i.rd = 5'($urandom); i.sel = 3'($urandom); i.f3 = 3'($urandom);
    i.pc = $urandom; i.pcw = ($urandom_range(0, 15) == 0) ? i.pc : $urandom;
    i.alu = $urandom; i.uimm = $urandom; i.rdata = $urandom;
    return i;
  endfunction

  task automatic drive(input bit st, input ins_t i);
    wb.stall_i = st; wb.valid_i = i.valid; wb.regwrite_i = i.regwrite; wb.cmp_i = i.cmp;
    wb.rd_i = i.rd; wb.wb_sel_i = i.sel; wb.funct3_i = i.f3; wb.pc_i = i.pc;
    wb.pc_wdata_i = i.pcw; wb.alu_i = i.alu; wb.u_imm_i = i.uimm; wb.mem_rdata_i = i.rdata;
  endtask

  task automatic check_out();
    check("we", wb.load_regfile_o, fresh && h.regwrite && h.rd != 5'd0);
    check("rd", wb.rd_o, h.rd);
    check("data", wb.regfile_in_o, exp_data(h));
    check("rvfi_valid", wb.rvfi_valid_o, fresh);
    check("order", wb.rvfi_order_o, cnt);
    check("pc", wb.rvfi_pc_o, h.pc);
`ifdef WB_HALT_DETECT_EN
    check("halt", wb.halt_o, halt_m);
`endif
    if (wb.rvfi_valid_o) pulses++;
  endtask

  // Each captured valid instruction retires once, in the cycle right after its capture edge.
  task automatic cycle(input bit st, input ins_t i);
    drive(st, i);
    @(posedge clk);
    if (fresh) begin
      if (h.pc == h.pcw) halt_m = 1'b1;
      cnt++;
    end
    if (!st) begin
      h = i;
      fresh = i.valid;
    end else
      fresh = 1'b0;
    @(negedge clk);
    check_out();
  endtask

  task automatic model_reset();
    h = zero_ins; fresh = 1'b0; cnt = '0; halt_m = 1'b0;
  endtask

  initial begin
    zero_ins = mk(0, 0, 5'd0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    zero_ins.pcw = 32'd4; zero_ins.cmp = 1'b0; zero_ins.uimm = 32'd0;
    model_reset();
    h.pcw = 32'd0;
    drive(0, zero_ins);
    repeat (2) @(negedge clk);
    check_out();
    rst = 1'b0;

    cycle(0, mk(1, 1, 5'd5, 3'd0, 3'd0, 32'h1234_5678, 32'd0, 32'h100));
    check("alu_we", wb.load_regfile_o, 1);
    check("alu_data", wb.regfile_in_o, 32'h1234_5678);
    check("alu_order", wb.rvfi_order_o, 0);
    cycle(0, mk(1, 1, 5'd0, 3'd0, 3'd0, 32'h55, 32'd0, 32'h104));
    check("x0_we", wb.load_regfile_o, 0);
    check("x0_valid", wb.rvfi_valid_o, 1);
    check("x0_order", wb.rvfi_order_o, 1);

    cycle(0, mk(1, 1, 5'd7, 3'd4, 3'd0, 32'h1000, 32'h80F0_7F81, 32'h108));
    check("lb", wb.regfile_in_o, 32'hFFFF_FF81);
    cycle(0, mk(1, 1, 5'd7, 3'd4, 3'd4, 32'h1003, 32'h80F0_7F81, 32'h10C));
    check("lbu", wb.regfile_in_o, 32'h0000_0080);
    cycle(0, mk(1, 1, 5'd7, 3'd4, 3'd1, 32'h1002, 32'h80F0_7F81, 32'h110));
    check("lh", wb.regfile_in_o, 32'hFFFF_80F0);
    cycle(0, mk(1, 1, 5'd7, 3'd4, 3'd5, 32'h1000, 32'h80F0_7F81, 32'h114));
    check("lhu", wb.regfile_in_o, 32'h0000_7F81);
    cycle(0, mk(1, 1, 5'd7, 3'd4, 3'd2, 32'h1001, 32'h80F0_7F81, 32'h118));
    check("lw", wb.regfile_in_o, 32'h80F0_7F81);

    pulses = 0;
    cycle(0, mk(1, 1, 5'd9, 3'd0, 3'd0, 32'hCAFE, 32'd0, 32'h11C));
    check("stall_order", wb.rvfi_order_o, 7);
    for (int k = 0; k < 4; k++) begin
      r = rnd();
      cycle(1, r);
    end
    check("stall_pulses", pulses, 1);
    check("stall_cnt", wb.rvfi_order_o, 8);

    cycle(0, mk(1, 1, 5'd3, 3'd0, 3'd0, 32'hBEEF, 32'd0, 32'h200));
    cycle(1, mk(1, 1, 5'd3, 3'd0, 3'd0, 32'hBEEF, 32'd0, 32'h200));
    #2 rst = 1'b1;
    #1;
    check("arst_we", wb.load_regfile_o, 0);
    check("arst_rd", wb.rd_o, 0);
    check("arst_data", wb.regfile_in_o, 0);
    check("arst_valid", wb.rvfi_valid_o, 0);
    check("arst_order", wb.rvfi_order_o, 0);
    check("arst_pc", wb.rvfi_pc_o, 0);
    model_reset();
    h.pcw = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    cycle(0, mk(1, 1, 5'd4, 3'd2, 3'd0, 32'd0, 32'd0, 32'h300));
    check("rst_first_valid", wb.rvfi_valid_o, 1);
    check("rst_first_order", wb.rvfi_order_o, 0);

    cycle(0, zero_ins);
    force dut.order = {OW{1'b1}};
    #1 release dut.order;
    cnt = {OW{1'b1}};
    cycle(0, mk(1, 1, 5'd1, 3'd0, 3'd0, 32'h11, 32'd0, 32'h40));
    check("wrap_a", wb.rvfi_order_o, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle(0, zero_ins);
    check("bubble_pulse", wb.rvfi_valid_o, 0);
    cycle(0, mk(1, 1, 5'd2, 3'd0, 3'd0, 32'h22, 32'd0, 32'h50));
    check("wrap_b", wb.rvfi_order_o, 0);
    r = mk(1, 1, 5'd3, 3'd0, 3'd0, 32'h33, 32'd0, 32'h60);
    r.pcw = 32'h60;
    cycle(0, r);
    check("wrap_c", wb.rvfi_order_o, 1);
    cycle(0, zero_ins);
    cycle(0, zero_ins);
`ifdef WB_HALT_DETECT_EN
    check("halt_set", wb.halt_o, 1);
`endif

    for (int k = 0; k < 400; k++) begin
      r = rnd();
      cycle(1'($urandom_range(0, 3) == 0), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
